pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core. It drives PC write-enable, IF/ID write/flush, ID/EX bubble insertion and the whole-pipe hold.
- It resolves three hazard sources: data-memory busy, taken branch or jump redirect from EX, and load-use dependency in ID.
- It keeps saturating stall and flush statistics counters readable by the testbench.

Parameters:
- FETCH_LAT, 1, extra cycles IF/ID flush stays asserted after a redirect cycle (instruction-memory latency); legal range 0..7.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- id_rs1  input  5  rs1 field of the instruction in ID
- id_rs2  input  5  rs2 field of the instruction in ID
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- ex_mem_read  input  1  EX instruction is a load
- ex_rd  input  5  EX destination register
- ex_redirect  input  1  EX resolved taken branch or jump (PC target valid)
- mem_busy  input  1  data memory not ready; pipe must freeze
- cnt_clear  input  1  synchronous clear of statistics counters
- pc_write  output  1  PC register load enable
- ifid_write  output  1  IF/ID register load enable
- ifid_flush  output  1  IF/ID loads NOP (0x00000013)
- idex_flush  output  1  ID/EX loads bubble (all control signals 0)
- pipe_hold  output  1  freeze EX/MEM/WB registers
- state  output  2  current FSM state (debug)
- stall_cnt  output  CNT_W  cycles with pc_write=0 (excluding reset)
- flush_cnt  output  CNT_W  redirect events applied

Behaviour:
- States: RUN=0, STALL=1, WAIT=2, FLUSH=3. A 1-bit redirect_pend register and a 3-bit flush_left counter are held internally.
- Control outputs are combinational from state, internal registers and inputs. state, redirect_pend, flush_left and the counters are registered.
- While rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0.
- Reset values: state=RUN, redirect_pend=0, flush_left=0, stall_cnt=0, flush_cnt=0.
- Load-use hazard (lu) = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Redirect request (rd_req) = ex_redirect | redirect_pend.
- Per-cycle priority, highest first:
  - 1) mem_busy=1: pc_write=0, ifid_write=0, pipe_hold=1, no flushes.
    - If ex_redirect=1, set redirect_pend=1.
    - Next state=WAIT. flush_left is frozen.
  - 2) rd_req=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1.
    - Clear redirect_pend. flush_cnt+1.
    - flush_left<=FETCH_LAT. Next state=FLUSH if FETCH_LAT>0, else RUN.
    - A load-use in the same cycle is discarded, because its ID instruction is flushed.
  - 3) state=FLUSH (flush_left>0): pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=0.
    - flush_left-1. Go to RUN when it reaches 0.
  - 4) lu=1: pc_write=0, ifid_write=0, idex_flush=1. Next state=STALL.
  - 5) Otherwise: pc_write=1, ifid_write=1, all flushes 0, pipe_hold=0. Next state=RUN.
- STALL lasts exactly one cycle, because the bubble leaves EX with ex_mem_read=0. A back-to-back lu in STALL re-applies priority 4.
- WAIT exits on the first cycle with mem_busy=0. That cycle is evaluated by the priority list, so a pending redirect is applied there.
- stall_cnt increments in every non-reset cycle with pc_write=0.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- cnt_clear=1 zeroes both counters and overrides an increment in the same cycle. It does not affect the FSM.
- rst mid-operation discards redirect_pend, flush_left and the current state. The FSM resumes in RUN on the first cycle after rst falls.
- rd and rs fields equal to x0 never cause a stall.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release. Required during reset: ifid_flush=1, idex_flush=1, pc_write=0. Required in the first cycle after reset: pc_write=1, state=0, both counters 0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle. Required: pc_write=0, ifid_write=0, idex_flush=1, state then 1, then 0, stall_cnt=1. Repeat with ex_rd=0: no stall.
- Redirect with FETCH_LAT=2: pulse ex_redirect for 1 cycle. Required: ifid_flush=1 for 3 consecutive cycles, idex_flush=1 only in the first, flush_cnt=1, state returns to 0.
- Busy plus redirect: mem_busy=1 for 3 cycles with ex_redirect=1 in the 2nd. Required: pipe_hold=1 and pc_write=0 for 3 cycles, then in the cycle mem_busy falls, ifid_flush=1, idex_flush=1, pc_write=1, and stall_cnt=3.
- Redirect plus load-use in the same cycle: only the redirect is applied. Required: pc_write=1, stall_cnt unchanged.
- Counters with CNT_W=2: 5 load-use stalls leave stall_cnt=3 (saturated). Then cnt_clear=1 gives stall_cnt=0 in the next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline sequencing controller for the 5-stage RISC-V core. Resolves
//   data-memory busy, EX redirect (taken branch/jump) and ID load-use hazards,
//   and keeps saturating stall/flush statistics.
//
// Parameters
//   FETCH_LAT : extra cycles IF/ID flush stays asserted after a redirect (0..7)
//   CNT_W     : width of the statistics counters
//
// Ports
//   clk, rst                : clock (rising edge), synchronous active-high reset
//   id_rs1/id_rs2           : source register fields of the ID instruction
//   id_uses_rs1/id_uses_rs2 : ID instruction actually reads rs1/rs2
//   ex_mem_read, ex_rd      : EX instruction is a load, and its destination
//   ex_redirect             : EX resolved a taken branch or jump
//   mem_busy                : data memory not ready, whole pipe freezes
//   cnt_clear               : synchronous clear of the statistics counters
//   pc_write, ifid_write    : PC and IF/ID load enables
//   ifid_flush, idex_flush  : IF/ID loads NOP, ID/EX loads a bubble
//   pipe_hold               : freeze EX/MEM/WB
//   state                   : current FSM state (debug)
//   stall_cnt, flush_cnt    : cycles with pc_write=0, redirects applied
module pipe_hazard_ctrl #(
    parameter int unsigned FETCH_LAT = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             redirect_pend_q, redirect_pend_d;
    logic [2:0]       flush_left_q, flush_left_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;
    logic rd_req;
    logic flush_inc;

    // A load into x0 never produces a value, so it cannot create a hazard.
    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign rd_req = ex_redirect || redirect_pend_q;

    always_comb begin
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        pipe_hold       = 1'b0;
        state_d         = RUN;
        redirect_pend_d = redirect_pend_q;
        flush_left_d    = flush_left_q;
        flush_inc       = 1'b0;

        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            if (ex_redirect) begin
                redirect_pend_d = 1'b1;
            end
            state_d = WAIT;
        end else if (rd_req) begin
            // Any load-use seen this cycle belongs to the flushed ID slot.
            ifid_flush      = 1'b1;
            idex_flush      = 1'b1;
            redirect_pend_d = 1'b0;
            flush_inc       = 1'b1;
            flush_left_d    = 3'(FETCH_LAT);
            state_d         = (FETCH_LAT > 0) ? FLUSH : RUN;
        end else if (flush_left_q != 3'd0) begin
            // Keyed on flush_left rather than state so that a flush window
            // interrupted by mem_busy resumes once WAIT is left.
            ifid_flush   = 1'b1;
            flush_left_d = flush_left_q - 3'd1;
            state_d      = (flush_left_q == 3'd1) ? RUN : FLUSH;
        end else if (lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_d    = STALL;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clear) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            redirect_pend_q <= 1'b0;
            flush_left_q    <= 3'd0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
            flush_left_q    <= flush_left_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share all inputs:
//   dut   : FETCH_LAT=2, CNT_W=16
//   dut_s : FETCH_LAT=0, CNT_W=2 (flush-window and saturation boundaries)
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit later, registered values 1 unit after the next edge.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_busy, cnt_clear;

    logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_pipe_hold;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FETCH_LAT(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy), .cnt_clear(cnt_clear),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .pipe_hold(pipe_hold), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.FETCH_LAT(0), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy), .cnt_clear(cnt_clear),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .pipe_hold(s_pipe_hold), .state(s_state),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; mem_busy = 1'b0; cnt_clear = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        for (int i = 0; i < 2; i++) begin
            #2;
            vectors++; if (pc_write !== 1'b0) begin miscompares++; $display("FAIL rst_pc_write got %b exp 0", pc_write); end
            vectors++; if (ifid_write !== 1'b0) begin miscompares++; $display("FAIL rst_ifid_write got %b exp 0", ifid_write); end
            vectors++; if (ifid_flush !== 1'b1) begin miscompares++; $display("FAIL rst_ifid_flush got %b exp 1", ifid_flush); end
            vectors++; if (idex_flush !== 1'b1) begin miscompares++; $display("FAIL rst_idex_flush got %b exp 1", idex_flush); end
            vectors++; if (pipe_hold !== 1'b0) begin miscompares++; $display("FAIL rst_pipe_hold got %b exp 0", pipe_hold); end
            next_cycle();
        end
        rst = 1'b0;
        #1;
        vectors++; if (pc_write !== 1'b1) begin miscompares++; $display("FAIL post_rst_pc_write got %b exp 1", pc_write); end
        vectors++; if (ifid_flush !== 1'b0) begin miscompares++; $display("FAIL post_rst_ifid_flush got %b exp 0", ifid_flush); end
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL post_rst_state got %0d exp 0", state); end
        vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL post_rst_stall_cnt got %0d exp 0", stall_cnt); end
        vectors++; if (flush_cnt !== 16'd0) begin miscompares++; $display("FAIL post_rst_flush_cnt got %0d exp 0", flush_cnt); end
        next_cycle();
    endtask

    task automatic test_load_use();
        set_lu();
        #1;
        vectors++; if (pc_write !== 1'b0) begin miscompares++; $display("FAIL lu_pc_write got %b exp 0", pc_write); end
        vectors++; if (ifid_write !== 1'b0) begin miscompares++; $display("FAIL lu_ifid_write got %b exp 0", ifid_write); end
        vectors++; if (idex_flush !== 1'b1) begin miscompares++; $display("FAIL lu_idex_flush got %b exp 1", idex_flush); end
        vectors++; if (ifid_flush !== 1'b0) begin miscompares++; $display("FAIL lu_ifid_flush got %b exp 0", ifid_flush); end
        next_cycle();
        idle();
        vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL lu_state_stall got %0d exp 1", state); end
        vectors++; if (stall_cnt !== 16'd1) begin miscompares++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
        #1;
        vectors++; if (pc_write !== 1'b1) begin miscompares++; $display("FAIL lu_release_pc_write got %b exp 1", pc_write); end
        next_cycle();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL lu_state_run got %0d exp 0", state); end
        // Load into x0 with a matching x0 source: no hazard.
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        #1;
        vectors++; if (pc_write !== 1'b1) begin miscompares++; $display("FAIL lu_x0_pc_write got %b exp 1", pc_write); end
        vectors++; if (idex_flush !== 1'b0) begin miscompares++; $display("FAIL lu_x0_idex_flush got %b exp 0", idex_flush); end
        // rs2 matches but is not read: no hazard.
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        #1;
        vectors++; if (pc_write !== 1'b1) begin miscompares++; $display("FAIL lu_rs2_unused_pc_write got %b exp 1", pc_write); end
        // rs2 matches and is read: hazard.
        id_uses_rs2 = 1'b1;
        #1;
        vectors++; if (pc_write !== 1'b0) begin miscompares++; $display("FAIL lu_rs2_pc_write got %b exp 0", pc_write); end
        idle();
        next_cycle();
        vectors++; if (stall_cnt !== 16'd1) begin miscompares++; $display("FAIL lu_x0_stall_cnt got %0d exp 1", stall_cnt); end
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL lu_x0_state got %0d exp 0", state); end
    endtask

    task automatic test_redirect();
        ex_redirect = 1'b1;
        #1;
        vectors++; if (ifid_flush !== 1'b1) begin miscompares++; $display("FAIL rd_c1_ifid_flush got %b exp 1", ifid_flush); end
        vectors++; if (idex_flush !== 1'b1) begin miscompares++; $display("FAIL rd_c1_idex_flush got %b exp 1", idex_flush); end
        vectors++; if (pc_write !== 1'b1) begin miscompares++; $display("FAIL rd_c1_pc_write got %b exp 1", pc_write); end
        vectors++; if (s_ifid_flush !== 1'b1) begin miscompares++; $display("FAIL rd0_c1_ifid_flush got %b exp 1", s_ifid_flush); end
        next_cycle();
        idle();
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL rd_c2_state got %0d exp 3", state); end
        vectors++; if (flush_cnt !== 16'd1) begin miscompares++; $display("FAIL rd_flush_cnt got %0d exp 1", flush_cnt); end
        vectors++; if (s_state !== 2'd0) begin miscompares++; $display("FAIL rd0_c2_state got %0d exp 0", s_state); end
        #1;
        vectors++; if (ifid_flush !== 1'b1) begin miscompares++; $display("FAIL rd_c2_ifid_flush got %b exp 1", ifid_flush); end
        vectors++; if (idex_flush !== 1'b0) begin miscompares++; $display("FAIL rd_c2_idex_flush got %b exp 0", idex_flush); end
        vectors++; if (s_ifid_flush !== 1'b0) begin miscompares++; $display("FAIL rd0_c2_ifid_flush got %b exp 0", s_ifid_flush); end
        next_cycle();
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL rd_c3_state got %0d exp 3", state); end
        vectors++; if (ifid_flush !== 1'b1) begin miscompares++; $display("FAIL rd_c3_ifid_flush got %b exp 1", ifid_flush); end
        vectors++; if (idex_flush !== 1'b0) begin miscompares++; $display("FAIL rd_c3_idex_flush got %b exp 0", idex_flush); end
        next_cycle();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rd_c4_state got %0d exp 0", state); end
        vectors++; if (ifid_flush !== 1'b0) begin miscompares++; $display("FAIL rd_c4_ifid_flush got %b exp 0", ifid_flush); end
    endtask

    task automatic test_busy_redirect();
        cnt_clear = 1'b1;
        next_cycle();
        cnt_clear = 1'b0;
        vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL clr_stall_cnt got %0d exp 0", stall_cnt); end
        vectors++; if (flush_cnt !== 16'd0) begin miscompares++; $display("FAIL clr_flush_cnt got %0d exp 0", flush_cnt); end
        for (int c = 0; c < 3; c++) begin
            mem_busy = 1'b1;
            ex_redirect = (c == 1);
            #1;
            vectors++; if (pipe_hold !== 1'b1) begin miscompares++; $display("FAIL busy_c%0d_pipe_hold got %b exp 1", c, pipe_hold); end
            vectors++; if (pc_write !== 1'b0) begin miscompares++; $display("FAIL busy_c%0d_pc_write got %b exp 0", c, pc_write); end
            vectors++; if (ifid_flush !== 1'b0) begin miscompares++; $display("FAIL busy_c%0d_ifid_flush got %b exp 0", c, ifid_flush); end
            vectors++; if (idex_flush !== 1'b0) begin miscompares++; $display("FAIL busy_c%0d_idex_flush got %b exp 0", c, idex_flush); end
            next_cycle();
            vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL busy_c%0d_state got %0d exp 2", c, state); end
        end
        idle();
        #1;
        vectors++; if (ifid_flush !== 1'b1) begin miscompares++; $display("FAIL busy_exit_ifid_flush got %b exp 1", ifid_flush); end
        vectors++; if (idex_flush !== 1'b1) begin miscompares++; $display("FAIL busy_exit_idex_flush got %b exp 1", idex_flush); end
        vectors++; if (pc_write !== 1'b1) begin miscompares++; $display("FAIL busy_exit_pc_write got %b exp 1", pc_write); end
        vectors++; if (pipe_hold !== 1'b0) begin miscompares++; $display("FAIL busy_exit_pipe_hold got %b exp 0", pipe_hold); end
        vectors++; if (stall_cnt !== 16'd3) begin miscompares++; $display("FAIL busy_stall_cnt got %0d exp 3", stall_cnt); end
        vectors++; if (s_stall_cnt !== 2'd3) begin miscompares++; $display("FAIL busy_s_stall_cnt got %0d exp 3", s_stall_cnt); end
        next_cycle();
        vectors++; if (flush_cnt !== 16'd1) begin miscompares++; $display("FAIL busy_flush_cnt got %0d exp 1", flush_cnt); end
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL busy_flush_state got %0d exp 3", state); end
        next_cycle();
        next_cycle();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL busy_end_state got %0d exp 0", state); end
    endtask

    task automatic test_redirect_lu();
        set_lu();
        ex_redirect = 1'b1;
        #1;
        vectors++; if (pc_write !== 1'b1) begin miscompares++; $display("FAIL rdlu_pc_write got %b exp 1", pc_write); end
        vectors++; if (ifid_flush !== 1'b1) begin miscompares++; $display("FAIL rdlu_ifid_flush got %b exp 1", ifid_flush); end
        vectors++; if (idex_flush !== 1'b1) begin miscompares++; $display("FAIL rdlu_idex_flush got %b exp 1", idex_flush); end
        next_cycle();
        idle();
        vectors++; if (stall_cnt !== 16'd3) begin miscompares++; $display("FAIL rdlu_stall_cnt got %0d exp 3", stall_cnt); end
        vectors++; if (flush_cnt !== 16'd2) begin miscompares++; $display("FAIL rdlu_flush_cnt got %0d exp 2", flush_cnt); end
        vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL rdlu_state got %0d exp 3", state); end
        next_cycle();
        next_cycle();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rdlu_end_state got %0d exp 0", state); end
    endtask

    task automatic test_back_to_back();
        cnt_clear = 1'b1;
        next_cycle();
        cnt_clear = 1'b0;
        for (int c = 0; c < 5; c++) begin
            set_lu();
            #1;
            vectors++; if (pc_write !== 1'b0) begin miscompares++; $display("FAIL b2b_c%0d_pc_write got %b exp 0", c, pc_write); end
            next_cycle();
            vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL b2b_c%0d_state got %0d exp 1", c, state); end
        end
        vectors++; if (stall_cnt !== 16'd5) begin miscompares++; $display("FAIL b2b_stall_cnt got %0d exp 5", stall_cnt); end
        vectors++; if (s_stall_cnt !== 2'd3) begin miscompares++; $display("FAIL sat_stall_cnt got %0d exp 3", s_stall_cnt); end
        // Clear wins over the increment of a stall in the same cycle.
        cnt_clear = 1'b1;
        next_cycle();
        cnt_clear = 1'b0;
        idle();
        vectors++; if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL clr_over_inc_stall_cnt got %0d exp 0", stall_cnt); end
        vectors++; if (s_stall_cnt !== 2'd0) begin miscompares++; $display("FAIL sat_clr_stall_cnt got %0d exp 0", s_stall_cnt); end
        vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL clr_state_kept got %0d exp 1", state); end
        next_cycle();
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL b2b_end_state got %0d exp 0", state); end
    endtask

    task automatic test_reset_mid();
        mem_busy = 1'b1;
        ex_redirect = 1'b1;
        next_cycle();
        idle();
        rst = 1'b1;
        #1;
        vectors++; if (pc_write !== 1'b0) begin miscompares++; $display("FAIL rstmid_pc_write got %b exp 0", pc_write); end
        vectors++; if (ifid_flush !== 1'b1) begin miscompares++; $display("FAIL rstmid_ifid_flush got %b exp 1", ifid_flush); end
        vectors++; if (pipe_hold !== 1'b0) begin miscompares++; $display("FAIL rstmid_pipe_hold got %b exp 0", pipe_hold); end
        next_cycle();
        rst = 1'b0;
        #1;
        vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rstmid_state got %0d exp 0", state); end
        vectors++; if (ifid_flush !== 1'b0) begin miscompares++; $display("FAIL rstmid_pend_dropped got %b exp 0", ifid_flush); end
        vectors++; if (pc_write !== 1'b1) begin miscompares++; $display("FAIL rstmid_after_pc_write got %b exp 1", pc_write); end
        vectors++; if (flush_cnt !== 16'd0) begin miscompares++; $display("FAIL rstmid_flush_cnt got %0d exp 0", flush_cnt); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_busy_redirect();
        test_redirect_lu();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
